// File: rtl/legup_arg_mem_slave_if.sv
// Avalon-MM slave bundle for the argument memory: request, address, data and
// lane mask from the master; read data and waitrequest back from the slave.
interface legup_arg_mem_slave_if #(
  parameter int BUS_SIZE  = 64,
  parameter int BUS_BYTES = 8,
  parameter int ADDR_W    = 8
);
  logic                 avs_read;
  logic                 avs_write;
  logic [ADDR_W-1:0]    avs_address;
  logic [BUS_SIZE-1:0]  avs_writedata;
  logic [BUS_BYTES-1:0] avs_byteenable;
  logic [BUS_SIZE-1:0]  avs_readdata;
  logic                 avs_waitrequest;

  modport master (
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/legup_arg_mem_slave.sv
// Dual-ported argument memory: an Avalon-MM slave with fixed wait states on one
// side and a simple host word port on the other, plus transfer counters.
module legup_arg_mem_slave #(
  parameter int BUS_SIZE    = 64,
  parameter int BUS_BYTES   = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  legup_arg_mem_slave_if.slave avs,
  input  logic                 hst_we,
  input  logic [ADDR_W-4:0]    hst_addr,
  input  logic [BUS_SIZE-1:0]  hst_wdata,
  output logic [BUS_SIZE-1:0]  hst_rdata,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic                 proto_err
);

  localparam int WORD_W = ADDR_W - 3;
  localparam int DEPTH  = 1 << WORD_W;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_next;
  logic                 r_op_read;
  logic [WORD_W-1:0]    r_word;
  logic [BUS_SIZE-1:0]  r_wdata;
  logic [BUS_BYTES-1:0] r_be;
  logic [BUS_SIZE-1:0]  r_readdata;
  logic [BUS_SIZE-1:0]  r_hst_rdata;
  logic [15:0]          r_rd_count;
  logic [15:0]          r_wr_count;
  logic                 r_proto_err;
  logic [BUS_SIZE-1:0]  r_mem [DEPTH];

  logic                 w_req;
  logic [WORD_W-1:0]    w_req_word;
  logic [WORD_W-1:0]    w_rd_word;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_load_rd;
  logic                 w_commit;
  logic                 w_rd_done;
  logic                 w_unused_addr;

  assign w_req         = avs.avs_read | avs.avs_write;
  assign w_req_word    = avs.avs_address[ADDR_W-1:3];
  assign w_unused_addr = ^avs.avs_address[2:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_accept        = 1'b0;
    w_abort         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (HAS_WAIT) begin
            w_next_state    = WAIT;
            w_wait_cnt_next = WAIT_LOAD;
          end else begin
            w_next_state = ACK;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end else if (r_wait_cnt == 4'd0) begin
          w_next_state = ACK;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // With no wait states the read word comes straight off the bus in IDLE.
  assign w_rd_word = (r_state == IDLE) ? w_req_word : r_word;
  assign w_load_rd = (w_accept && !HAS_WAIT && avs.avs_read) ||
                     (r_state == WAIT && w_next_state == ACK && r_op_read);
  assign w_commit  = (r_state == ACK) && !r_op_read;
  assign w_rd_done = (r_state == ACK) && r_op_read;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata  <= '0;
      r_hst_rdata <= '0;
      r_rd_count  <= 16'd0;
      r_wr_count  <= 16'd0;
      r_proto_err <= 1'b0;
      r_op_read   <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      r_hst_rdata <= r_mem[hst_addr];
      if (w_accept) begin
        r_op_read <= avs.avs_read;
        r_word    <= w_req_word;
        r_wdata   <= avs.avs_writedata;
        r_be      <= avs.avs_byteenable;
      end
      if (w_load_rd) begin
        r_readdata <= r_mem[w_rd_word];
      end
      if (w_rd_done && r_rd_count != 16'hFFFF) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (w_commit && r_wr_count != 16'hFFFF) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if ((w_accept && avs.avs_read && avs.avs_write) || w_abort) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Slave lanes are assigned after the host word so they win on a same-word collision.
  always_ff @(posedge clk) begin
    if (hst_we) begin
      r_mem[hst_addr] <= hst_wdata;
    end
    if (w_commit && reset_n) begin
      for (int b = 0; b < BUS_BYTES; b++) begin
        if (r_be[b]) begin
          r_mem[r_word][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign avs.avs_readdata    = r_readdata;
  assign avs.avs_waitrequest = (r_state != ACK);
  assign hst_rdata           = r_hst_rdata;
  assign rd_count            = r_rd_count;
  assign wr_count            = r_wr_count;
  assign proto_err           = r_proto_err;

endmodule

// File: tb/tb_legup_arg_mem_slave.sv
// Directed and randomized checks of the argument memory slave against a
// word-array reference model, with a second zero-wait-state instance.
module tb_legup_arg_mem_slave;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        hstWe;
  logic [4:0]  hstAddr;
  logic [63:0] hstWdata;
  logic [63:0] hstRdata;
  logic [15:0] rdCount;
  logic [15:0] wrCount;
  logic        protoErr;

  logic        bHstWe;
  logic [4:0]  bHstAddr;
  logic [63:0] bHstWdata;
  logic [63:0] bHstRdata;
  logic [15:0] bRdCount;
  logic [15:0] bWrCount;
  logic        bProtoErr;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [32];
  logic [15:0] mRd;
  logic [15:0] mWr;
  logic        mErr;
  logic [63:0] mLastRead;

  legup_arg_mem_slave_if ifA ();
  legup_arg_mem_slave_if ifB ();

  legup_arg_mem_slave #(.WAIT_STATES(2)) dutA (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (ifA),
    .hst_we    (hstWe),
    .hst_addr  (hstAddr),
    .hst_wdata (hstWdata),
    .hst_rdata (hstRdata),
    .rd_count  (rdCount),
    .wr_count  (wrCount),
    .proto_err (protoErr)
  );

  legup_arg_mem_slave #(.WAIT_STATES(0)) dutB (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (ifB),
    .hst_we    (bHstWe),
    .hst_addr  (bHstAddr),
    .hst_wdata (bHstWdata),
    .hst_rdata (bHstRdata),
    .rd_count  (bRdCount),
    .wr_count  (bWrCount),
    .proto_err (bProtoErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelSlaveWrite(input int w, input logic [63:0] d, input logic [7:0] be);
    for (int b = 0; b < 8; b++) begin
      if (be[b]) mem[w][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic hostWrite(input logic [4:0] a, input logic [63:0] d);
    hstWe = 1'b1; hstAddr = a; hstWdata = d;
    @(negedge clk);
    hstWe = 1'b0;
    mem[a] = d;
  endtask

  task automatic hostRead(input logic [4:0] a, output logic [63:0] d);
    hstAddr = a;
    @(negedge clk);
    d = hstRdata;
  endtask

  // One slave transfer on instance A; optionally a host write lands on the commit edge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] addr,
                               input logic [63:0] wd, input logic [7:0] be,
                               input bit hostAtAck, input logic [4:0] hA, input logic [63:0] hD,
                               output logic [63:0] rdata, output int waits);
    ifA.avs_read = rd; ifA.avs_write = wr; ifA.avs_address = addr;
    ifA.avs_writedata = wd; ifA.avs_byteenable = be;
    waits = 0;
    while (ifA.avs_waitrequest === 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("xferAck", {63'b0, ifA.avs_waitrequest}, 64'd0);
    rdata = ifA.avs_readdata;
    if (hostAtAck) begin
      hstWe = 1'b1; hstAddr = hA; hstWdata = hD;
    end
    ifA.avs_read = 1'b0; ifA.avs_write = 1'b0;
    @(negedge clk);
    hstWe = 1'b0;
  endtask

  initial begin
    logic [63:0] rdata;
    logic [63:0] hd;
    logic [63:0] dA;
    logic [63:0] dB;
    int          waits;

    reset_n = 1'b0;
    hstWe = 1'b0; hstAddr = '0; hstWdata = '0;
    bHstWe = 1'b0; bHstAddr = '0; bHstWdata = '0;
    ifA.avs_read = 1'b0; ifA.avs_write = 1'b0; ifA.avs_address = '0;
    ifA.avs_writedata = '0; ifA.avs_byteenable = '0;
    ifB.avs_read = 1'b0; ifB.avs_write = 1'b0; ifB.avs_address = '0;
    ifB.avs_writedata = '0; ifB.avs_byteenable = '0;
    mRd = 16'd0; mWr = 16'd0; mErr = 1'b0; mLastRead = 64'd0;

    repeat (3) @(negedge clk);
    checkOutput("rstWaitreq", {63'b0, ifA.avs_waitrequest}, 64'd1);
    checkOutput("rstReaddata", ifA.avs_readdata, 64'd0);
    checkOutput("rstHstRdata", hstRdata, 64'd0);
    checkOutput("rstRdCount", {48'b0, rdCount}, 64'd0);
    checkOutput("rstWrCount", {48'b0, wrCount}, 64'd0);
    checkOutput("rstProtoErr", {63'b0, protoErr}, 64'd0);
    checkOutput("rstBWaitreq", {63'b0, ifB.avs_waitrequest}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Zero-wait-state instance: two back-to-back reads with one IDLE gap.
    dA = {$urandom, $urandom};
    dB = {$urandom, $urandom};
    bHstWe = 1'b1; bHstAddr = 5'd2; bHstWdata = dA;
    @(negedge clk);
    bHstAddr = 5'd7; bHstWdata = dB;
    @(negedge clk);
    bHstWe = 1'b0;
    ifB.avs_read = 1'b1; ifB.avs_address = 8'h10;
    checkOutput("b2bIssue1", {63'b0, ifB.avs_waitrequest}, 64'd1);
    @(negedge clk);
    checkOutput("b2bAck1", {63'b0, ifB.avs_waitrequest}, 64'd0);
    checkOutput("b2bData1", ifB.avs_readdata, dA);
    ifB.avs_address = 8'h3C;
    @(negedge clk);
    checkOutput("b2bGap", {63'b0, ifB.avs_waitrequest}, 64'd1);
    @(negedge clk);
    checkOutput("b2bAck2", {63'b0, ifB.avs_waitrequest}, 64'd0);
    checkOutput("b2bData2", ifB.avs_readdata, dB);
    ifB.avs_read = 1'b0;
    @(negedge clk);
    checkOutput("b2bRdCount", {48'b0, bRdCount}, 64'd2);

    for (int i = 0; i < 32; i++) hostWrite(5'(i), {$urandom, $urandom});

    hostWrite(5'd3, 64'h1122334455667788);
    applyStimulus(1'b1, 1'b0, 8'h18, 64'd0, 8'h00, 1'b0, 5'd0, 64'd0, rdata, waits);
    mRd = satInc(mRd); mLastRead = mem[3];
    checkOutput("rdLatency", 64'(waits), 64'd3);
    checkOutput("rdData", rdata, 64'h1122334455667788);
    checkOutput("rdCount1", {48'b0, rdCount}, 64'd1);

    applyStimulus(1'b0, 1'b1, 8'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 5'd0, 64'd0, rdata, waits);
    modelSlaveWrite(3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); mWr = satInc(mWr);
    hostRead(5'd3, hd);
    checkOutput("wrLanes", hd, 64'h11223344FFFFFFFF);
    checkOutput("wrCount1", {48'b0, wrCount}, 64'd1);
    checkOutput("readdataHeld", ifA.avs_readdata, mLastRead);

    applyStimulus(1'b0, 1'b1, 8'h28, 64'h5555_5555_5555_5555, 8'hF0, 1'b1, 5'd5,
                  64'hAAAA_AAAA_AAAA_AAAA, rdata, waits);
    mem[5] = 64'hAAAA_AAAA_AAAA_AAAA;
    modelSlaveWrite(5, 64'h5555_5555_5555_5555, 8'hF0); mWr = satInc(mWr);
    hostRead(5'd5, hd);
    checkOutput("sameEdgeMerge", hd, 64'h55555555AAAAAAAA);
    checkOutput("protoErrClean", {63'b0, protoErr}, 64'd0);

    // Request withdrawn during the wait phase.
    ifA.avs_write = 1'b1; ifA.avs_address = 8'h30;
    ifA.avs_writedata = 64'hDEAD_BEEF_DEAD_BEEF; ifA.avs_byteenable = 8'hFF;
    @(negedge clk);
    ifA.avs_write = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("dropWaitreq", {63'b0, ifA.avs_waitrequest}, 64'd1);
    checkOutput("dropProtoErr", {63'b0, protoErr}, 64'd1);
    checkOutput("dropWrCount", {48'b0, wrCount}, {48'b0, mWr});
    hostRead(5'd6, hd);
    checkOutput("dropNoCommit", hd, mem[6]);

    // Reset pulsed in the middle of a later write's wait phase.
    ifA.avs_write = 1'b1;
    @(negedge clk);
    reset_n = 1'b0; ifA.avs_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mRd = 16'd0; mWr = 16'd0; mLastRead = 64'd0;
    checkOutput("midRstWaitreq", {63'b0, ifA.avs_waitrequest}, 64'd1);
    checkOutput("midRstRdCount", {48'b0, rdCount}, 64'd0);
    checkOutput("midRstWrCount", {48'b0, wrCount}, 64'd0);
    checkOutput("midRstProtoErr", {63'b0, protoErr}, 64'd0);
    checkOutput("midRstReaddata", ifA.avs_readdata, 64'd0);
    @(negedge clk);
    checkOutput("midRstIdle", {63'b0, ifA.avs_waitrequest}, 64'd1);
    checkOutput("midRstWrStill0", {48'b0, wrCount}, 64'd0);
    hostRead(5'd6, hd);
    checkOutput("midRstNoCommit", hd, mem[6]);
    hostRead(5'd3, hd);
    checkOutput("memKeptOverRst", hd, mem[3]);

    // Read and write both asserted: treated as a read, write suppressed.
    applyStimulus(1'b1, 1'b1, 8'h1B, 64'h0, 8'hFF, 1'b0, 5'd0, 64'd0, rdata, waits);
    mRd = satInc(mRd); mLastRead = mem[3];
    checkOutput("bothRdData", rdata, mem[3]);
    checkOutput("bothProtoErr", {63'b0, protoErr}, 64'd1);
    checkOutput("bothWrCount", {48'b0, wrCount}, 64'd0);
    checkOutput("bothRdCount", {48'b0, rdCount}, 64'd1);
    hostRead(5'd3, hd);
    checkOutput("bothMemSame", hd, mem[3]);

    for (int it = 0; it < 60; it++) begin
      int          op;
      logic [7:0]  a;
      logic [63:0] d;
      logic [7:0]  be;
      logic [4:0]  ha;
      logic [63:0] hdat;
      bit          hx;
      op = $urandom_range(0, 3);
      a = 8'($urandom);
      d = {$urandom, $urandom};
      be = 8'($urandom);
      ha = 5'($urandom);
      hdat = {$urandom, $urandom};
      hx = bit'($urandom_range(0, 1));
      case (op)
        0: hostWrite(ha, hdat);
        1: begin
          applyStimulus(1'b1, 1'b0, a, d, be, 1'b0, 5'd0, 64'd0, rdata, waits);
          mRd = satInc(mRd); mLastRead = mem[a[7:3]];
          checkOutput("rndRdData", rdata, mLastRead);
          checkOutput("rndRdLatency", 64'(waits), 64'd3);
        end
        2: begin
          applyStimulus(1'b0, 1'b1, a, d, be, hx, ha, hdat, rdata, waits);
          if (hx) mem[ha] = hdat;
          modelSlaveWrite(int'(a[7:3]), d, be); mWr = satInc(mWr);
          checkOutput("rndWrHeld", ifA.avs_readdata, mLastRead);
        end
        default: begin
          hostRead(ha, hd);
          checkOutput("rndHostRead", hd, mem[ha]);
        end
      endcase
      checkOutput("rndRdCount", {48'b0, rdCount}, {48'b0, mRd});
      checkOutput("rndWrCount", {48'b0, wrCount}, {48'b0, mWr});
    end

    for (int w = 0; w < 32; w++) begin
      hostRead(5'(w), hd);
      checkOutput("finalMem", hd, mem[w]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/legup_arg_mem_slave.md
LEGUP_ARG_MEM_SLAVE -- requirements
Module: legup_arg_mem_slave

Interface
REQ-001 The block SHALL have parameter BUS_SIZE, default 64, meaning data bus width in bits.
REQ-002 The block SHALL have parameter BUS_BYTES, default 8, meaning byte lanes (BUS_SIZE/8).
REQ-003 The block SHALL have parameter ADDR_W, default 8, meaning byte-address width; depth is 2^ADDR_W/BUS_BYTES words (32 words at default).
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, meaning extra waitrequest-high cycles per transfer (legal range 0..15).
REQ-005 The block SHALL have a single clock, with port clk, input, width 1, as the rising-edge clock.
REQ-006 The block SHALL have port reset_n, input, width 1, as its reset; reset_n is synchronous and active-low.
REQ-007 The block SHALL have port avs_read, input, width 1, as the Avalon-MM slave read request.
REQ-008 The block SHALL have port avs_write, input, width 1, as the Avalon-MM slave write request.
REQ-009 The block SHALL have port avs_address, input, ADDR_W wide, as the byte address; word index = avs_address[ADDR_W-1:3], and bits [2:0] are ignored.
REQ-010 The block SHALL have port avs_writedata, input, BUS_SIZE wide, as the write data.
REQ-011 The block SHALL have port avs_byteenable, input, BUS_BYTES wide, as the write lane mask.
REQ-012 The block SHALL have port avs_readdata, output, BUS_SIZE wide, as the read data.
REQ-013 The block SHALL have port avs_waitrequest, output, width 1, which stalls the master.
REQ-014 The block SHALL have port hst_we, input, width 1, as the host-side word write strobe.
REQ-015 The block SHALL have port hst_addr, input, ADDR_W-3 wide, as the host word index.
REQ-016 The block SHALL have port hst_wdata, input, BUS_SIZE wide, as the host write data (all lanes written).
REQ-017 The block SHALL have port hst_rdata, output, BUS_SIZE wide, as host read data, registered with 1-cycle latency from hst_addr.
REQ-018 The block SHALL have ports rd_count and wr_count, outputs, 16 bits each, as completed-transfer counters.
REQ-019 The block SHALL have port proto_err, output, width 1, as a sticky protocol-violation flag.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, WAIT, and ACK.
REQ-021 In IDLE, when avs_read or avs_write is high, the block SHALL latch op/word/data/byteenable and go to WAIT if WAIT_STATES>0, else to ACK.
REQ-022 In WAIT, a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle, and the FSM SHALL go to ACK when it reaches 0.
REQ-023 avs_waitrequest SHALL be low only in ACK; it SHALL be high in IDLE and WAIT, including when no request is present.
REQ-024 A transfer SHALL complete on the ACK cycle; total latency from first request cycle to ACK is 1+WAIT_STATES cycles.
REQ-025 For a read, avs_readdata SHALL be loaded on the edge entering ACK from the latched word and held until the next read enters ACK.
REQ-026 A write SHALL commit on the edge leaving ACK, updating only lanes with byteenable=1, and SHALL NOT be visible to a read completing in that same ACK.
REQ-027 ACK SHALL always return to IDLE; back-to-back requests therefore incur one IDLE cycle with waitrequest high.
REQ-028 If avs_read and avs_write are both high in IDLE, the block SHALL treat the request as a read, suppress the write, and set proto_err.
REQ-029 If the request drops during WAIT, the block SHALL return to IDLE, discard the transfer with no commit and no count, and set proto_err.
REQ-030 A host write SHALL commit at the clock edge when hst_we=1, in any FSM state.
REQ-031 When a host write and a slave commit hit the same word on the same edge, the slave-enabled lanes SHALL take the slave data and the remaining lanes SHALL take the host data.
REQ-032 rd_count and wr_count SHALL each increment by 1 on the respective ACK and saturate at 0xFFFF.

Reset
REQ-033 While reset_n=0 at a rising edge, the block SHALL set FSM=IDLE, avs_waitrequest=1, avs_readdata=0, hst_rdata=0, counters=0, proto_err=0, and the wait counter to 0.
REQ-034 Reset SHALL NOT clear memory contents; a transfer in progress SHALL be aborted with no commit and no count.
REQ-035 After release, reset_n=0 asserted mid-WAIT SHALL yield IDLE with waitrequest=1 on the following cycle.

Verification
REQ-036 Host writes word 3 = 0x1122334455667788, then slave read at address 0x18 with WAIT_STATES=2 -> waitrequest high 3 cycles, then readdata=0x1122334455667788 in ACK, rd_count=1.
REQ-037 Slave write to address 0x18 with data 0xFFFF..FF and byteenable 0x0F -> hst_rdata of word 3 = 0x11223344FFFFFFFF, wr_count=1.
REQ-038 With WAIT_STATES=0, two back-to-back reads -> each completes 1 cycle after issue, with one IDLE gap between them.
REQ-039 avs_read and avs_write both high -> read data returned, memory unchanged, proto_err=1, wr_count unchanged.
REQ-040 Request dropped in WAIT, then reset_n pulsed low mid-WAIT of a later write -> no commit, counters=0 after reset, waitrequest=1.
REQ-041 Same-edge host write (0xAA..AA) and slave write (0x55..55, byteenable 0xF0) to word 5 -> word 5 = 0x55555555AAAAAAAA.
